// File: rtl/phi_sweeper.sv
// phi_sweeper: Jacobi iteration sequencer and double-buffered phi grid owner.
//
// The two phi banks live in one array indexed by {bank, y, x}. Bank 'sel'
// is the read bank and bank '~sel' is the write bank. During a sweep the block
// streams every grid address once, in raster order, to the solver. It accepts
// the solver's write-backs into the write bank. Once every write-back of the
// sweep has landed, it swaps the banks. This repeats for num_iter iterations.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, num_iter     run request (sampled in IDLE) and iteration count
//   busy, done          not-IDLE flag, one-cycle end-of-run pulse
//   iter_count          completed iterations of the current/last run
//   wr_err              sticky: write-back arrived while not sweeping/draining
//   valid, grid_addr    raster address stream {y,x} to the solver
//   raddr, rdata        NRD packed read ports, 1-cycle latency, read bank
//   wvalid/waddr/wdata  solver write-back into the write bank
//   load_en/addr/data   host initial-phi write into the read bank (IDLE only)
module phi_sweeper #(
  parameter int XBITS  = 4,
  parameter int YBITS  = 4,
  parameter int DWIDTH = 24,
  parameter int NRD    = 4,
  parameter int AW     = XBITS + YBITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            num_iter,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            iter_count,
  output logic                  wr_err,
  output logic                  valid,
  output logic [AW-1:0]         grid_addr,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*DWIDTH-1:0] rdata,
  input  logic                  wvalid,
  input  logic [AW-1:0]         waddr,
  input  logic [DWIDTH-1:0]     wdata,
  input  logic                  load_en,
  input  logic [AW-1:0]         load_addr,
  input  logic [DWIDTH-1:0]     load_data
);

  localparam int DEPTH = 1 << AW;
  // Write-back count that marks a complete sweep (2^AW).
  localparam logic [AW:0] WB_FULL = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SWEEP  = 3'd1,
    DRAIN  = 3'd2,
    SWAP   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic            sel_reg;
  logic [AW-1:0]   issue_cnt_reg;
  logic [AW:0]     wb_cnt_reg;
  logic [7:0]      num_iter_reg;
  logic [7:0]      iter_count_reg;
  logic            wr_err_reg;

  logic [DWIDTH-1:0] mem [0:2*DEPTH-1];
  logic [DWIDTH-1:0] rdata_reg [NRD];

  logic            start_accept;
  logic            load_accept;
  logic            wb_accept;
  logic            wb_drop;
  logic            mem_we;
  logic [AW:0]     mem_widx;
  logic [DWIDTH-1:0] mem_wdata;

  assign start_accept = start && (state_reg == IDLE);
  assign load_accept  = load_en && (state_reg == IDLE);
  assign wb_accept    = wvalid && ((state_reg == SWEEP) || (state_reg == DRAIN));
  assign wb_drop      = wvalid && ((state_reg == IDLE) || (state_reg == SWAP) ||
                                   (state_reg == FINISH));

  // Host loads and solver write-backs never coexist (IDLE versus
  // SWEEP/DRAIN), so they share a single write port.
  assign mem_we    = load_accept || wb_accept;
  assign mem_widx  = load_accept ? {sel_reg, load_addr} : {~sel_reg, waddr};
  assign mem_wdata = load_accept ? load_data : wdata;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start) state_next = (num_iter == 8'd0) ? FINISH : SWEEP;
      SWEEP:  if (&issue_cnt_reg) state_next = DRAIN;
      DRAIN:  if (wb_cnt_reg == WB_FULL) state_next = SWAP;
      SWAP:   state_next = ((iter_count_reg + 8'd1) == num_iter_reg) ? FINISH : SWEEP;
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      sel_reg        <= 1'b0;
      issue_cnt_reg  <= '0;
      wb_cnt_reg     <= '0;
      num_iter_reg   <= 8'd0;
      iter_count_reg <= 8'd0;
      wr_err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (start_accept) begin
        num_iter_reg   <= num_iter;
        iter_count_reg <= 8'd0;
      end

      // The issue counter wraps to 0 after the last address, so it is
      // already 0 when the next sweep begins.
      if (state_reg == SWAP) begin
        issue_cnt_reg <= '0;
      end else if (state_reg == SWEEP) begin
        issue_cnt_reg <= issue_cnt_reg + 1'b1;
      end

      if (state_reg == SWAP) begin
        wb_cnt_reg <= '0;
      end else if (wb_accept) begin
        wb_cnt_reg <= wb_cnt_reg + 1'b1;
      end

      if (state_reg == SWAP) begin
        sel_reg        <= ~sel_reg;
        iter_count_reg <= iter_count_reg + 8'd1;
      end

      // If a stray write-back and a start arrive together, the error
      // flag wins. That keeps the stray write-back visible.
      if (wb_drop) begin
        wr_err_reg <= 1'b1;
      end else if (start_accept) begin
        wr_err_reg <= 1'b0;
      end
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  // Each read port samples the bank selected in the address cycle. A read
  // that collides with a same-cycle write returns the old word.
  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_reg[gi] <= '0;
        end else begin
          rdata_reg[gi] <= mem[{sel_reg, raddr[gi*AW +: AW]}];
        end
      end
      assign rdata[gi*DWIDTH +: DWIDTH] = rdata_reg[gi];
    end
  endgenerate

  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == FINISH);
  assign valid      = (state_reg == SWEEP);
  assign grid_addr  = issue_cnt_reg;
  assign iter_count = iter_count_reg;
  assign wr_err     = wr_err_reg;

endmodule

// File: tb/tb_phi_sweeper.sv
// tb_phi_sweeper: randomized self-checking bench for phi_sweeper.
// A model solver with a fixed latency writes back rdata+1 for every issued
// address. The reference model tracks only the contents of the read bank.
// After an n-iteration run, each word has grown by n, and the bank select
// has toggled n times.
module tb_phi_sweeper;
  localparam int LAT = 22;
  localparam int N   = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   num_iter;
  logic         busy, done, wr_err, valid;
  logic [7:0]   iter_count;
  logic [7:0]   grid_addr;
  logic [31:0]  raddr;
  logic [95:0]  rdata;
  logic         wvalid;
  logic [7:0]   waddr;
  logic [23:0]  wdata;
  logic         load_en;
  logic [7:0]   load_addr;
  logic [23:0]  load_data;

  phi_sweeper #(.XBITS(4), .YBITS(4), .DWIDTH(24), .NRD(4), .AW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_iter(num_iter),
    .busy(busy), .done(done), .iter_count(iter_count), .wr_err(wr_err),
    .valid(valid), .grid_addr(grid_addr), .raddr(raddr), .rdata(rdata),
    .wvalid(wvalid), .waddr(waddr), .wdata(wdata),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int k0 = 0;

  logic [23:0] exp_rd [N];
  logic        exp_sel = 1'b0;

  logic [7:0]  host_r [4];
  logic        host_wv = 1'b0;
  logic [7:0]  host_waddr = 8'd0;
  logic [23:0] host_wdata = 24'd0;

  typedef struct {
    int          cyc;
    logic [7:0]  a;
    logic [23:0] d;
  } wb_t;
  wb_t         wb_q[$];
  logic        sol_wv = 1'b0;
  logic [7:0]  sol_waddr = 8'd0;
  logic [23:0] sol_wdata = 24'd0;
  logic        pv = 1'b0;
  logic [7:0]  pa = 8'd0;

  // Port 0 carries the solver's read whenever an address is being issued.
  assign raddr  = {host_r[3], host_r[2], host_r[1], valid ? grid_addr : host_r[0]};
  assign wvalid = sol_wv | host_wv;
  assign waddr  = sol_wv ? sol_waddr : host_waddr;
  assign wdata  = sol_wv ? sol_wdata : host_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  // Model solver: the address issued in cycle t is read in cycle t+1.
  // Its value+1 is written back in cycle t+LAT.
  task automatic solver_step();
    if (rst) begin
      wb_q.delete();
      pv     = 1'b0;
      sol_wv = 1'b0;
    end else begin
      if (pv) wb_q.push_back('{cyc - 1 + LAT, pa, rdata[23:0] + 24'd1});
      sol_wv = 1'b0;
      if (wb_q.size() > 0 && wb_q[0].cyc == cyc) begin
        sol_wv    = 1'b1;
        sol_waddr = wb_q[0].a;
        sol_wdata = wb_q[0].d;
        void'(wb_q.pop_front());
      end
      pv = valid;
      pa = grid_addr;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    solver_step();
  endtask

  task automatic load_all(input bit rnd);
    for (int a = 0; a < N; a++) begin
      tick();
      load_en   = 1'b1;
      load_addr = 8'(a);
      load_data = rnd ? 24'($urandom) : 24'(a);
      exp_rd[a] = load_data;
    end
    tick();
    load_en = 1'b0;
  endtask

  task automatic read_rand(input string tag);
    logic [7:0] a [4];
    tick();
    for (int p = 0; p < 4; p++) begin
      a[p] = 8'($urandom);
      host_r[p] = a[p];
    end
    tick();
    for (int p = 0; p < 4; p++) check(tag, {8'd0, rdata[p*24 +: 24]}, {8'd0, exp_rd[a[p]]});
  endtask

  task automatic read_one(input string tag, input logic [7:0] a, input logic [23:0] expv);
    tick();
    host_r[0] = a;
    host_r[3] = a;
    tick();
    check({tag, "_p0"}, {8'd0, rdata[23:0]}, {8'd0, expv});
    check({tag, "_p3"}, {8'd0, rdata[95:72]}, {8'd0, expv});
  endtask

  task automatic start_run(input int n);
    tick();
    start    = 1'b1;
    num_iter = 8'(n);
    k0       = cyc;
  endtask

  task automatic wait_done(input string tag, input bit hold, input bit load_mid,
                           input int n, input int exp_valid);
    int vc = 0, incs = 0, lat = 0, lo, hi;
    bit seen = 1'b0;
    logic [7:0] last_it;
    last_it = iter_count;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      if (!hold) start = 1'b0;
      load_en = 1'b0;
      if (iter_count == last_it + 8'd1) incs++;
      last_it = iter_count;
      if (valid) begin
        check({tag, "_gaddr"}, {24'd0, grid_addr}, 32'(vc % N));
        vc++;
        if (load_mid && vc == 10) begin
          load_en   = 1'b1;
          load_addr = 8'd37;
          load_data = 24'hABCDEF;
        end
      end
      if (done) begin
        seen = 1'b1;
        lat  = cyc - k0;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (n == 0) begin
      lo = 1;
      hi = 1;
    end else begin
      lo = n * (N + LAT + 2) - 1;
      hi = n * (N + LAT + 2) + 1 + n;
    end
    check({tag, "_lat_in_range"}, 32'(lat >= lo && lat <= hi), 32'd1);
    check({tag, "_valid_cycles"}, 32'(vc), 32'(exp_valid));
    check({tag, "_iter_incs"}, 32'(incs), 32'(n));
  endtask

  task automatic apply_run(input int n);
    for (int a = 0; a < N; a++) exp_rd[a] = exp_rd[a] + 24'(n);
    exp_sel = exp_sel ^ n[0];
  endtask

  initial begin
    bit sawv, reached;
    rst = 1'b1; start = 1'b0; num_iter = 8'd0;
    load_en = 1'b0; load_addr = 8'd0; load_data = 24'd0;
    for (int p = 0; p < 4; p++) host_r[p] = 8'd0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_iter", 32'(iter_count), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_gaddr", 32'(grid_addr), 32'd0);
    check("rst_rdata", 32'(|rdata), 32'd0);
    check("rst_sel", 32'(dut.sel_reg), 32'd0);
    rst = 1'b0;

    // Load an identity pattern, then run with zero iterations.
    load_all(1'b0);
    read_rand("load_rd");
    start_run(0);
    wait_done("it0", 1'b0, 1'b0, 0, 0);
    check("it0_iter", 32'(iter_count), 32'd0);
    check("it0_sel", 32'(dut.sel_reg), 32'(exp_sel));
    read_one("it0_rd37", 8'd37, 24'd37);

    // Single iteration.
    start_run(1);
    wait_done("it1", 1'b0, 1'b0, 1, N);
    apply_run(1);
    check("it1_iter", 32'(iter_count), 32'd1);
    check("it1_sel", 32'(dut.sel_reg), 32'(exp_sel));
    read_one("it1_rd37", 8'd37, 24'd38);
    read_rand("it1_rd");

    // Three iterations from a fresh identity pattern.
    load_all(1'b0);
    start_run(3);
    wait_done("it3", 1'b0, 1'b0, 3, 3 * N);
    apply_run(3);
    check("it3_iter", 32'(iter_count), 32'd3);
    check("it3_sel", 32'(dut.sel_reg), 32'(exp_sel));
    read_one("it3_rd200", 8'd200, 24'd203);
    read_rand("it3_rd");

    // A stray write-back in IDLE sets wr_err and leaves the memory unchanged.
    tick();
    host_wv = 1'b1; host_waddr = 8'd5; host_wdata = 24'h123456;
    tick();
    host_wv = 1'b0;
    check("wrerr_set", 32'(wr_err), 32'd1);
    read_one("wrerr_rd5", 8'd5, exp_rd[5]);
    check("wrerr_sticky", 32'(wr_err), 32'd1);
    start_run(0);
    wait_done("wrerr_clr_run", 1'b0, 1'b0, 0, 0);
    check("wrerr_cleared", 32'(wr_err), 32'd0);

    // Reset asserted in the drain phase of iteration 2.
    load_all(1'b1);
    start_run(3);
    sawv = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      tick();
      start = 1'b0;
      if (iter_count == 8'd1 && valid) sawv = 1'b1;
      if (sawv && busy && !valid) reached = 1'b1;
    end
    check("rst_mid_reached_drain", 32'(reached), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_valid", 32'(valid), 32'd0);
    check("rst_mid_iter", 32'(iter_count), 32'd0);
    check("rst_mid_sel", 32'(dut.sel_reg), 32'd0);
    tick();
    rst = 1'b0;
    exp_sel = 1'b0;
    load_all(1'b1);
    start_run(2);
    wait_done("post_rst", 1'b0, 1'b0, 2, 2 * N);
    apply_run(2);
    check("post_rst_wr_err", 32'(wr_err), 32'd0);
    read_rand("post_rst_rd");
    read_rand("post_rst_rd2");

    // Start held through a whole run. A load during SWEEP is ignored.
    start_run(1);
    wait_done("hold1", 1'b1, 1'b1, 1, N);
    tick();
    check("hold_idle_gap_busy", 32'(busy), 32'd0);
    check("hold_idle_gap_done", 32'(done), 32'd0);
    k0 = cyc;
    wait_done("hold2", 1'b0, 1'b0, 1, N);
    apply_run(2);
    check("hold_sel", 32'(dut.sel_reg), 32'(exp_sel));
    read_one("hold_rd37", 8'd37, exp_rd[37]);
    read_rand("hold_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
